// File: rtl/store_buffer.sv
// In-order store buffer between MEM and the data memory write port.
// Define STORE_BUFFER_ALIGN_CHECK_EN to drop misaligned stores and flag misalign_err.
module store_buffer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    st_valid,
    output logic                    st_ready,
    input  logic [1:0]              st_size,
    input  logic [ADDR_W-1:0]       st_addr,
    input  logic [DATA_W-1:0]       st_data,
    output logic                    mem_valid,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W/8-1:0]     mem_byteen,
    output logic [DATA_W-1:0]       mem_wdata,
    input  logic [ADDR_W-1:0]       ld_addr,
    output logic                    ld_conflict,
    output logic [$clog2(DEPTH):0]  count
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    ,
    output logic                    misalign_err
`endif
);

    localparam int NB = DATA_W / 8;
    localparam int LB = $clog2(NB);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [1:0]        lg;
    logic [LB-1:0]     off;
    logic [LB-1:0]     off_mask;
    logic [LB-1:0]     off_eff;
    logic [NB-1:0]     be_base;
    logic [NB-1:0]     lane_be;
    logic [DATA_W-1:0] data_m;
    logic [DATA_W-1:0] lane_data;
    logic [ADDR_W-1:0] lane_addr;

    logic [ADDR_W-1:0] ent_addr_q [DEPTH];
    logic [ADDR_W-1:0] ent_addr_d [DEPTH];
    logic [NB-1:0]     ent_be_q   [DEPTH];
    logic [NB-1:0]     ent_be_d   [DEPTH];
    logic [DATA_W-1:0] ent_wd_q   [DEPTH];
    logic [DATA_W-1:0] ent_wd_d   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot;

    logic accept;
    logic push;
    logic pop;

    // lg is log2 of the access size, clamped to the memory width
    always_comb begin
        lg        = (int'(st_size) > LB) ? 2'(LB) : st_size;
        off       = st_addr[LB-1:0];
        off_mask  = LB'((1 << lg) - 1);
        off_eff   = off & ~off_mask;
        be_base   = '0;
        data_m    = '0;
        for (int i = 0; i < NB; i++) begin
            if (i < (1 << lg)) begin
                be_base[i]      = 1'b1;
                data_m[8*i +: 8] = st_data[8*i +: 8];
            end
        end
        lane_be   = be_base << off_eff;
        lane_data = data_m << {off_eff, 3'b000};
        lane_addr = {st_addr[ADDR_W-1:LB], {LB{1'b0}}};
    end

    assign st_ready  = (count_q != CW'(DEPTH));
    assign mem_valid = (count_q != '0);
    assign accept    = st_valid && st_ready;
    assign pop       = mem_valid && mem_ready;

`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    logic misalign;
    logic err_q, err_d;

    assign misalign     = |(off & off_mask);
    assign push         = accept && !misalign;
    assign err_d        = accept && misalign;
    assign misalign_err = err_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`else
    assign push = accept;
`endif

    always_comb begin
        ent_addr_d = ent_addr_q;
        ent_be_d   = ent_be_q;
        ent_wd_d   = ent_wd_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (push) begin
            ent_addr_d[wr_ptr_q] = lane_addr;
            ent_be_d[wr_ptr_q]   = lane_be;
            ent_wd_d[wr_ptr_q]   = lane_data;
            wr_ptr_d             = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_addr_q[i] <= '0;
                ent_be_q[i]   <= '0;
                ent_wd_q[i]   <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            ent_addr_q <= ent_addr_d;
            ent_be_q   <= ent_be_d;
            ent_wd_q   <= ent_wd_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    assign mem_addr   = ent_addr_q[rd_ptr_q];
    assign mem_byteen = ent_be_q[rd_ptr_q];
    assign mem_wdata  = ent_wd_q[rd_ptr_q];
    assign count      = count_q;

    // Only slots between rd_ptr and rd_ptr+count hold live stores
    always_comb begin
        ld_conflict = 1'b0;
        slot        = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot = PW'(i) - rd_ptr_q;
            if (({1'b0, slot} < count_q) &&
                (((ent_addr_q[i] ^ ld_addr) >> LB) == '0)) begin
                ld_conflict = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Directed checks for store_buffer (32-bit and 64-bit instances).
module tb_store_buffer;

    logic        clk;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [1:0]  st_size;
    logic [31:0] st_addr;
    logic [31:0] st_data;
    logic        mem_valid;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byteen;
    logic [31:0] mem_wdata;
    logic [31:0] ld_addr;
    logic        ld_conflict;
    logic [2:0]  count;
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    logic        misalign_err;
`endif

    logic        w_st_valid;
    logic        w_st_ready;
    logic [1:0]  w_st_size;
    logic [31:0] w_st_addr;
    logic [63:0] w_st_data;
    logic        w_mem_valid;
    logic        w_mem_ready;
    logic [31:0] w_mem_addr;
    logic [7:0]  w_mem_byteen;
    logic [63:0] w_mem_wdata;
    logic [31:0] w_ld_addr;
    logic        w_ld_conflict;
    logic [2:0]  w_count;
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
    logic        w_misalign_err;
`endif

    int nvec  = 0;
    int nfail = 0;

    store_buffer #(.DATA_W(32), .ADDR_W(32), .DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_size(st_size),
        .st_addr(st_addr), .st_data(st_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_byteen(mem_byteen), .mem_wdata(mem_wdata),
        .ld_addr(ld_addr), .ld_conflict(ld_conflict), .count(count)
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
        , .misalign_err(misalign_err)
`endif
    );

    store_buffer #(.DATA_W(64), .ADDR_W(32), .DEPTH(4)) dut64 (
        .clk(clk), .reset(reset),
        .st_valid(w_st_valid), .st_ready(w_st_ready), .st_size(w_st_size),
        .st_addr(w_st_addr), .st_data(w_st_data),
        .mem_valid(w_mem_valid), .mem_ready(w_mem_ready),
        .mem_addr(w_mem_addr), .mem_byteen(w_mem_byteen),
        .mem_wdata(w_mem_wdata),
        .ld_addr(w_ld_addr), .ld_conflict(w_ld_conflict), .count(w_count)
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
        , .misalign_err(w_misalign_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wd;
    } vec_t;

    vec_t tbl [6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] a, input logic [31:0] d);
        st_valid = 1'b1;
        st_size  = 2'd2;
        st_addr  = a;
        st_data  = d;
        step();
        st_valid = 1'b0;
    endtask

    initial begin
        tbl[0] = '{2'd0, 32'h1003, 32'h0000_00AB, 32'h1000, 4'b1000, 32'hAB00_0000};
        tbl[1] = '{2'd1, 32'h2002, 32'hFFFF_1234, 32'h2000, 4'b1100, 32'h1234_0000};
        tbl[2] = '{2'd2, 32'h3000, 32'hDEAD_BEEF, 32'h3000, 4'b1111, 32'hDEAD_BEEF};
        tbl[3] = '{2'd3, 32'h5004, 32'h1122_3344, 32'h5004, 4'b1111, 32'h1122_3344};
        tbl[4] = '{2'd0, 32'h6001, 32'hFFFF_FF5A, 32'h6000, 4'b0010, 32'h0000_5A00};
        tbl[5] = '{2'd1, 32'h7000, 32'hABCD_EF01, 32'h7000, 4'b0011, 32'h0000_EF01};

        reset = 1'b0;
        st_valid = 1'b0; st_size = '0; st_addr = '0; st_data = '0;
        mem_ready = 1'b0; ld_addr = 32'hFFFF_FFF0;
        w_st_valid = 1'b0; w_st_size = '0; w_st_addr = '0; w_st_data = '0;
        w_mem_ready = 1'b0; w_ld_addr = '0;
        step();
        step();
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_mem_valid", 64'(mem_valid), 64'd0);
        chk("rst_st_ready", 64'(st_ready), 64'd1);
        chk("rst_ld_conflict", 64'(ld_conflict), 64'd0);
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
        chk("rst_misalign_err", 64'(misalign_err), 64'd0);
`endif
        reset = 1'b1;
        step();

        // Single-store lane vectors: one cycle after accept, then drain
        for (int v = 0; v < 6; v++) begin
            st_valid = 1'b1;
            st_size  = tbl[v].size;
            st_addr  = tbl[v].addr;
            st_data  = tbl[v].data;
            step();
            st_valid = 1'b0;
            chk($sformatf("v%0d_valid", v), 64'(mem_valid), 64'd1);
            chk($sformatf("v%0d_addr", v), 64'(mem_addr), 64'(tbl[v].e_addr));
            chk($sformatf("v%0d_be", v), 64'(mem_byteen), 64'(tbl[v].e_be));
            chk($sformatf("v%0d_wdata", v), 64'(mem_wdata), 64'(tbl[v].e_wd));
            mem_ready = 1'b1;
            step();
            mem_ready = 1'b0;
            chk($sformatf("v%0d_drained", v), 64'(count), 64'd0);
        end

        // Fill with mem_ready low: fifth store must stall
        st_valid = 1'b1;
        st_size  = 2'd2;
        for (int k = 0; k < 5; k++) begin
            st_addr = 32'h100 + 32'(4 * k);
            st_data = 32'hC0DE_0000 + 32'(k);
            chk($sformatf("fill%0d_st_ready", k), 64'(st_ready),
                64'(k < 4));
            step();
        end
        st_valid = 1'b0;
        chk("full_count", 64'(count), 64'd4);
        mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("drain%0d_addr", k), 64'(mem_addr),
                64'(32'h100 + 32'(4 * k)));
            chk($sformatf("drain%0d_wdata", k), 64'(mem_wdata),
                64'(32'hC0DE_0000 + 32'(k)));
            step();
        end
        mem_ready = 1'b0;
        chk("drain_empty", 64'(mem_valid), 64'd0);

        // Simultaneous enqueue and dequeue at count 2
        push_word(32'h200, 32'hA);
        push_word(32'h204, 32'hB);
        chk("sim_pre_count", 64'(count), 64'd2);
        st_valid = 1'b1; st_addr = 32'h208; st_data = 32'hC;
        mem_ready = 1'b1;
        step();
        st_valid = 1'b0;
        chk("sim_count", 64'(count), 64'd2);
        chk("sim_head1", 64'(mem_addr), 64'h204);
        step();
        chk("sim_head2", 64'(mem_addr), 64'h208);
        step();
        mem_ready = 1'b0;
        chk("sim_empty", 64'(count), 64'd0);

        // Misaligned word at 0x3002
        st_valid = 1'b1; st_size = 2'd2;
        st_addr = 32'h3002; st_data = 32'h5566_7788;
        step();
        st_valid = 1'b0;
`ifdef STORE_BUFFER_ALIGN_CHECK_EN
        chk("mis_err_pulse", 64'(misalign_err), 64'd1);
        chk("mis_count", 64'(count), 64'd0);
        chk("mis_valid", 64'(mem_valid), 64'd0);
        step();
        chk("mis_err_clear", 64'(misalign_err), 64'd0);
`else
        chk("mis_addr", 64'(mem_addr), 64'h3000);
        chk("mis_be", 64'(mem_byteen), 64'hF);
        chk("mis_wdata", 64'(mem_wdata), 64'h5566_7788);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("mis_drained", 64'(count), 64'd0);
`endif

        // Load hazard
        st_valid = 1'b1; st_size = 2'd2;
        st_addr = 32'h4000; st_data = 32'h1;
        ld_addr = 32'h4000;
        #1;
        chk("ld_enq_excluded", 64'(ld_conflict), 64'd0);
        step();
        st_valid = 1'b0;
        ld_addr = 32'h4001;
        #1;
        chk("ld_hit", 64'(ld_conflict), 64'd1);
        ld_addr = 32'h4004;
        #1;
        chk("ld_miss", 64'(ld_conflict), 64'd0);
        ld_addr = 32'h4001;
        mem_ready = 1'b1;
        #1;
        chk("ld_hit_deq", 64'(ld_conflict), 64'd1);
        step();
        mem_ready = 1'b0;
        chk("ld_after_drain", 64'(ld_conflict), 64'd0);
        ld_addr = 32'hFFFF_FFF0;

        // Reset mid-cycle with three entries queued
        push_word(32'h500, 32'h1);
        push_word(32'h504, 32'h2);
        push_word(32'h508, 32'h3);
        chk("rst3_count", 64'(count), 64'd3);
        #3;
        reset = 1'b0;
        #1;
        chk("rstmid_count", 64'(count), 64'd0);
        chk("rstmid_valid", 64'(mem_valid), 64'd0);
        mem_ready = 1'b1;
        step();
        reset = 1'b1;
        step();
        chk("rstpost_valid", 64'(mem_valid), 64'd0);
        step();
        chk("rstpost_count", 64'(count), 64'd0);
        mem_ready = 1'b0;

        // 64-bit memory: dword and byte lanes
        w_st_valid = 1'b1; w_st_size = 2'd3;
        w_st_addr = 32'h10; w_st_data = 64'h1122_3344_5566_7788;
        step();
        w_st_size = 2'd0; w_st_addr = 32'h15;
        w_st_data = 64'hFFFF_FFFF_FFFF_FFAB;
        step();
        w_st_valid = 1'b0;
        chk("w_dw_addr", 64'(w_mem_addr), 64'h10);
        chk("w_dw_be", 64'(w_mem_byteen), 64'hFF);
        chk("w_dw_wdata", w_mem_wdata, 64'h1122_3344_5566_7788);
        w_mem_ready = 1'b1;
        step();
        chk("w_b_addr", 64'(w_mem_addr), 64'h10);
        chk("w_b_be", 64'(w_mem_byteen), 64'h20);
        chk("w_b_wdata", w_mem_wdata, 64'h0000_AB00_0000_0000);
        step();
        w_mem_ready = 1'b0;
        chk("w_empty", 64'(w_count), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
# store_buffer

Parametrised store buffer between the MEM stage and the data memory write port. Accepts store requests of byte/half/word/dword size, computes the byte-lane enables and lane-shifted write data for a DATA_W-bit memory, queues up to DEPTH stores in order, and drains them through a valid/ready handshake. It also flags a load hazard when a pending store targets the same memory word.

## Interface
- DATA_W, 32, memory data width in bits; 32 or 64. NB = DATA_W/8, LB = log2(NB).
- ADDR_W, 32, byte-address width.
- DEPTH, 4, queue entries; power of two, at least 2.

- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  one clock; reset is asynchronous and active-low. reset = 0 clears all state immediately.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept; equals !full.
- st_size  in  2  0 byte, 1 half, 2 word, 3 dword; sizes wider than NB clamp to NB bytes.
- st_addr  in  ADDR_W  byte address.
- st_data  in  DATA_W  store value, right-aligned.
- mem_valid  out  1  head entry valid; equals !empty.
- mem_ready  in  1  memory accepts head entry.
- mem_addr  out  ADDR_W  head address, low LB bits zero.
- mem_byteen  out  NB  head byte enables.
- mem_wdata  out  DATA_W  head lane-shifted data.
- ld_addr  in  ADDR_W  address of the load in MEM.
- ld_conflict  out  1  a queued entry has the same word address as ld_addr.
- count  out  log2(DEPTH)+1  occupied entries.
- misalign_err  out  1  misaligned store dropped; present only with the macro.

## Operation
- Lane computation on accept: bytes = min(1<<st_size, NB); off = st_addr[LB-1:0]; byteen = ((1<<bytes)-1) << off; wdata = (st_data masked to bytes*8 bits) << (8*off); stored address = st_addr with the low LB bits cleared.
- Alignment: a request is misaligned if off is not a multiple of bytes. Handling is set by the macro (see Configuration).
- Enqueue when st_valid && st_ready. Entry is written at wr_ptr, and wr_ptr increments mod DEPTH.
- Dequeue when mem_valid && mem_ready. rd_ptr increments mod DEPTH. mem_* are driven directly from the entry at rd_ptr.
- Simultaneous enqueue and dequeue: both happen and count is unchanged. When full, st_ready = 0 even if a dequeue occurs in the same cycle; there is no full-bypass.
- Empty: mem_valid = 0, and mem_addr/byteen/wdata are don't-care but stable.
- ld_conflict is combinational over the valid entries only. It includes the entry being dequeued this cycle and excludes the request being enqueued this cycle. The pipeline stalls the load while it is 1.
- Ordering is strict FIFO, with no coalescing.

## Timing
- Reset values: count 0, pointers 0, mem_valid 0, st_ready 1, ld_conflict 0, misalign_err 0. Reset mid-operation discards all entries.
- Latency: a store accepted in cycle N appears on mem_* at the earliest in cycle N+1 (empty queue).
- Throughput: one enqueue and one dequeue per cycle.
- count reflects state after the last edge. st_ready/mem_valid derive from registered count only.
- misalign_err is registered: it is a 1-cycle pulse in cycle N+1 for a misaligned store handshaken in cycle N.

## Configuration
- STORE_BUFFER_ALIGN_CHECK_EN defined: a misaligned request still completes its handshake but is not enqueued, count does not change, and misalign_err pulses.
- Not defined: there is no misalign_err port. off is rounded down to a multiple of bytes, and the store is enqueued aligned.

## Test plan
- DATA_W=32, byte store addr 0x1003 data 0x000000AB -> mem_addr 0x1000, byteen 4'b1000, wdata 0xAB000000, one cycle after accept.
- DATA_W=32, half store addr 0x2002 data 0xFFFF1234 -> byteen 4'b1100, wdata 0x12340000. DATA_W=64, dword store addr 0x10 -> byteen 8'hFF.
- mem_ready=0, five back-to-back word stores -> st_ready drops after the 4th and count=4. Then mem_ready=1 -> four writes drain in order, one per cycle. Simultaneous enqueue/dequeue at count=2 -> count stays 2.
- Word store at 0x3002: with the macro, misalign_err=1 for one cycle and count unchanged. Without it, byteen 4'b1111 at addr 0x3000.
- Queued word store at 0x4000, ld_addr 0x4001 -> ld_conflict=1. ld_addr 0x4004 -> 0. After drain -> 0.
- With 3 entries queued, drive reset low mid-cycle -> count=0, mem_valid=0 immediately, and no further mem writes.
